// File: rtl/diff_q_pkg.sv
// diff_q_pkg: shared states, colour codes, default widths and row mapping for the diff_q plot path
package diff_q_pkg;
  localparam int DEF_DATA_W = 10;
  localparam int DEF_ROW_W = 9;
  localparam int DEF_COL_W = 9;
  localparam int DEF_Y_CENTER = 240;
  localparam int DEF_Y_MAX = 479;
  typedef enum logic [3:0] {
    IDLE, INIT, STEP, ERASE1, ERASE2, PLOT1, PLOT2, WRITEBACK, ADVANCE
  } state_t;
  localparam logic [1:0] C_ERASE = 2'd0;
  localparam logic [1:0] C_X1 = 2'd1;
  localparam logic [1:0] C_X2 = 2'd2;
  // screen rows grow downwards, so positive x moves the trace up
  function automatic logic [15:0] row_of(input logic signed [15:0] x, input int yc, input int ym);
    int y;
    y = yc - int'(x >>> 1);
    return y < 0 ? 16'd0 : y > ym ? 16'(ym) : 16'(y);
  endfunction
endpackage

// File: rtl/col_history.sv
// col_history: per-column store of the last plotted row pair, sync read with 1-cycle latency
module col_history #(
  parameter int DEPTH = 320,
  parameter int AW = 9,
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0] rd_data
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/diff_q_sched.sv
// diff_q_sched: steps the diff_q solver, decimates its output and streams erase/plot pixels per column
module diff_q_sched
  import diff_q_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N_COLS = 320,
  parameter int COL_W = DEF_COL_W,
  parameter int ROW_W = DEF_ROW_W,
  parameter int Y_CENTER = DEF_Y_CENTER,
  parameter int Y_MAX = DEF_Y_MAX,
  parameter int STEP_DIV = 4,
  parameter int SOLVER_LAT = 1
) (
  input  logic              slow_clk,
  input  logic              reset,
  input  logic              run,
  input  logic              restart,
  output logic              solver_init,
  output logic              solver_step,
  input  logic [DATA_W-1:0] x1,
  input  logic [DATA_W-1:0] x2,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [COL_W-1:0]  pix_x,
  output logic [ROW_W-1:0]  pix_y,
  output logic [1:0]        pix_color,
  output logic [COL_W-1:0]  col,
  output logic              busy,
  output logic              frame_done
);
  state_t state;
  logic first_pass, inited, restart_pend;
  logic [7:0] ph;
  logic [15:0] steps;
  logic [ROW_W-1:0] y1, y2, h1, h2;
  logic need1, need2, act_rst, cap, last;
  col_history #(.DEPTH(N_COLS), .AW(COL_W), .W(2*ROW_W)) u_hist (
    .clk(slow_clk),
    .wr_en(state == WRITEBACK),
    .wr_addr(col),
    .wr_data({y1, y2}),
    .rd_en(cap),
    .rd_addr(col),
    .rd_data({h1, h2})
  );
  always_comb begin
    need1 = !first_pass && h1 != y1;
    need2 = !first_pass && h2 != y2;
    pix_valid = state == ERASE1 ? need1 : state == ERASE2 || state == PLOT1 || state == PLOT2;
    pix_y = state == ERASE1 ? h1 : state == ERASE2 ? h2 : state == PLOT1 ? y1 : state == PLOT2 ? y2 : '0;
    pix_color = state == PLOT1 ? C_X1 : state == PLOT2 ? C_X2 : C_ERASE;
    act_rst = (restart || restart_pend) && (!pix_valid || pix_ready);
    cap = state == STEP && ph == 8'(SOLVER_LAT) && steps == 16'(STEP_DIV - 1);
    last = col == COL_W'(N_COLS - 1);
  end
  assign pix_x = col;
  assign busy = state != IDLE;
  assign solver_init = state == INIT;
  assign solver_step = state == STEP && ph == 8'd0;
  assign frame_done = state == ADVANCE && last;
  always_ff @(posedge slow_clk) begin
    if (reset) begin
      state <= IDLE;
      first_pass <= 1'b1;
      inited <= 1'b0;
      restart_pend <= 1'b0;
      ph <= '0;
      steps <= '0;
      col <= '0;
      y1 <= '0;
      y2 <= '0;
    end else begin
      restart_pend <= (restart || restart_pend) && !act_rst;
      if (act_rst) begin
        // a restart abandons the column; uninitialised IDLE defers INIT until run
        inited <= 1'b0;
        first_pass <= 1'b1;
        col <= '0;
        state <= (state == IDLE && !run) ? IDLE : INIT;
      end else begin
        case (state)
          IDLE: if (run) state <= inited ? STEP : INIT;
          INIT: begin
            col <= '0;
            first_pass <= 1'b1;
            inited <= 1'b1;
            ph <= '0;
            steps <= '0;
            state <= STEP;
          end
          STEP: begin
            if (ph == 8'(SOLVER_LAT)) begin
              ph <= '0;
              steps <= cap ? '0 : steps + 16'd1;
              if (cap) begin
                y1 <= ROW_W'(row_of(16'($signed(x1)), Y_CENTER, Y_MAX));
                y2 <= ROW_W'(row_of(16'($signed(x2)), Y_CENTER, Y_MAX));
                state <= ERASE1;
              end
            end else ph <= ph + 8'd1;
          end
          ERASE1: if (!need1 || pix_ready) state <= need2 ? ERASE2 : PLOT1;
          ERASE2: if (pix_ready) state <= PLOT1;
          PLOT1: if (pix_ready) state <= PLOT2;
          PLOT2: if (pix_ready) state <= WRITEBACK;
          WRITEBACK: state <= ADVANCE;
          ADVANCE: begin
            col <= last ? '0 : col + 1'b1;
            if (last) first_pass <= 1'b0;
            state <= run ? STEP : IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/diff_q_sched.md
Name: diff_q_sched

Overview:
Sequencer for the coupled-oscillator ODE solver (diff_q) and the VGA plot path.
- Initialises the solver and pulses one integration step at a time.
- Decimates solver output: one sample per STEP_DIV steps.
- Converts x1/x2 to screen rows and emits erase and plot pixel writes to the frame-buffer writer over a valid/ready handshake, one column per sample, wrapping across the screen as a scrolling trace.

Parameters:
DATA_W, 10, solver state width (signed)
N_COLS, 320, plotted columns per sweep
COL_W, 9, column index width
ROW_W, 9, row index width
Y_CENTER, 240, screen row for x = 0
Y_MAX, 479, last valid row
STEP_DIV, 4, solver steps per plotted column (≥1)
SOLVER_LAT, 1, cycles from solver_step to valid x1/x2

Ports:
slow_clk  in  1  solver/sequencer clock
reset  in  1  synchronous, active-high
run  in  1  level; 1 = advance, 0 = pause at next column boundary
restart  in  1  pulse; re-initialise solver and return to column 0
solver_init  out  1  load x1_0/x2_0 into diff_q
solver_step  out  1  one-cycle integration step pulse
x1  in  DATA_W  solver position 1 (signed)
x2  in  DATA_W  solver position 2 (signed)
pix_valid  out  1  pixel write request
pix_ready  in  1  frame-buffer writer accepts
pix_x  out  COL_W  column
pix_y  out  ROW_W  row
pix_color  out  2  0 = erase, 1 = x1 trace, 2 = x2 trace
col  out  COL_W  current column
busy  out  1  state ≠ IDLE
frame_done  out  1  one-cycle pulse on column wrap

Behaviour:
- Reset values: all outputs 0; state IDLE; first_pass = 1; step count 0.
- IDLE:
  - run=1 and never initialised (after reset or restart) → INIT.
  - run=1 and initialised → STEP, resuming with no re-init.
- INIT: solver_init=1 for exactly 1 cycle; col=0; first_pass=1 → STEP.
- STEP:
  - Pulse solver_step for 1 cycle, wait SOLVER_LAT cycles, increment step count.
  - After STEP_DIV steps: capture x1/x2, compute rows, read history RAM at col → ERASE1.
- Row mapping: y = Y_CENTER − (x >>> 1), computed in DATA_W+2 signed bits, clamped to [0, Y_MAX]. Examples: x = 0 → 240; x = 300 → 90; x = −512 → 479 (496 clamped).
- ERASE1/ERASE2: emit stored y1 then y2 with color 0.
  - Both skipped when first_pass=1.
  - Skipped individually when the stored row equals the new row of the same trace.
- PLOT1: emit y1, color 1. PLOT2: emit y2, color 2.
- Handshake (ERASE1, ERASE2, PLOT1, PLOT2):
  - pix_valid held with x/y/color stable until pix_valid & pix_ready.
  - Transfer on that edge; move to next state. pix_ready may be high early or tied high.
  - Each pixel takes ≥1 cycle.
- WRITEBACK: store y1,y2 at col (1 cycle) → ADVANCE.
- ADVANCE:
  - col = N_COLS−1: col→0, frame_done pulse, first_pass→0.
  - Otherwise col+1.
  - Then STEP if run=1, else IDLE.
- Pause: run sampled only in ADVANCE and IDLE. Lowering run mid-column completes that column.
- restart:
  - Latched into restart_pend.
  - Acted on in any state where pix_valid=0, or on the cycle a handshake completes.
  - Next state INIT; pending pixel not emitted; history contents don't matter (first_pass=1).
  - restart during IDLE with run=0: goes to IDLE uninitialised (INIT taken on run).
- reset mid-handshake: pix_valid drops next cycle (consumer tolerates).
- Simultaneous restart and col wrap: frame_done still pulses; restart wins the next state.
- Latency, run high, pix_ready tied high, first_pass:
  - STEP_DIV·(1+SOLVER_LAT) + 5 cycles per column.
  - Defaults: 13 cycles/column.

Decomposition:
- Package diff_q_pkg:
  - state enum (IDLE, INIT, STEP, ERASE1, ERASE2, PLOT1, PLOT2, WRITEBACK, ADVANCE)
  - color codes
  - DATA_W, ROW_W, COL_W defaults
  - Y_CENTER, Y_MAX
- Sub-module col_history:
  - N_COLS × 2·ROW_W simple dual-port RAM.
  - Synchronous read, 1-cycle latency; write in WRITEBACK.
- Row mapping is a function in diff_q_pkg.

Test Plan:
- Reset held 3 cycles, run=1, pix_ready=1, stub solver x1=0, x2=300 → 1 solver_init pulse; per column 4 solver_step pulses then (col,240,1),(col,90,2); no erase during first sweep.
- 320 columns run → frame_done pulses once at wrap (col 319→0); column 0 of the next sweep erases 240/90 only if the rows changed; same rows → no erase pixels.
- x1 = −512, x2 = 511 → rows 479 and 0 (clamping).
- pix_ready low 5 cycles during PLOT1 → pix_valid stays high with x/y/color stable; exactly one transfer; no extra solver_step pulses.
- run dropped mid-column 10 → column 10 finishes, col=11, IDLE, busy=0; run re-raised → no solver_init, resumes at col 11.
- restart pulsed while PLOT2 stalled (pix_ready=0) → completes after the handshake; next cycle INIT, solver_init=1, col=0, first_pass erase suppression verified.
